// File: rtl/timer_tima.sv
`default_nettype none
// ============================================================================
//  Module   : timer_tima
//  Purpose  : Programmable timer block (TIMA FF05, TMA FF06, TAC FF07).
//             Counts falling edges of the TAC-selected divider tap in TIMA.
//             On TIMA overflow it reads 0x00 for OVF_DELAY cycles, then
//             reloads from TMA and pulses int_timer for one cycle.
//  Revision : 1.0  initial release
//  Config   : TIMER_TAC_GLITCH_EN
//               defined   - the edge detector watches the tac[2]-gated
//                           source, so a TAC change can create a spurious
//                           increment (hardware-accurate behaviour)
//               undefined - the edge detector watches the ungated tap and is
//                           cleared by TAC writes, so TAC writes never count
//  Ports    : clk           M-cycle clock, all state on rising edge
//             nreset        asynchronous active-low reset
//             tap_4096hz    divider tap for TAC[1:0]=00
//             tap_262144hz  divider tap for TAC[1:0]=01
//             tap_65536hz   divider tap for TAC[1:0]=10
//             tap_16384hz   divider tap for TAC[1:0]=11
//             ff05/06/07    decoded register selects (mutually exclusive)
//             cpu_wr        write strobe, d sampled on clk rise
//             cpu_rd        read strobe, d driven combinationally
//             d             8-bit bidirectional CPU data bus
//             int_timer     one-cycle timer interrupt request
// ============================================================================
module timer_tima #(
    parameter int         OVF_DELAY = 1,        // legal 1..3
    parameter logic [4:0] TAC_FILL  = 5'b11111
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       tap_4096hz,
    input  logic       tap_262144hz,
    input  logic       tap_65536hz,
    input  logic       tap_16384hz,
    input  logic       ff05,
    input  logic       ff06,
    input  logic       ff07,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    inout  wire  [7:0] d,
    output logic       int_timer
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OVF    = 2'd1;
    localparam logic [1:0] ST_RELOAD = 2'd2;

    localparam logic [1:0] CNT_INIT = OVF_DELAY[1:0];

    logic [7:0] tima;
    logic [7:0] tma;
    logic [2:0] tac;
    logic [1:0] state;
    logic [1:0] cnt;
    logic       edge_prev;

    logic       wr_tima;
    logic       wr_tma;
    logic       wr_tac;
    logic       tap_sel;
    logic       edge_next;
    logic       inc;
    logic [7:0] tma_next;
    logic [7:0] rd_data;
    logic       rd_en;

    assign wr_tima = ff05 & cpu_wr;
    assign wr_tma  = ff06 & cpu_wr;
    assign wr_tac  = ff07 & cpu_wr;

    // Reload sees a TMA write landing in the same cycle.
    assign tma_next = wr_tma ? d : tma;

    always_comb begin
        tap_sel = tap_4096hz;
        case (tac[1:0])
            2'b00:   tap_sel = tap_4096hz;
            2'b01:   tap_sel = tap_262144hz;
            2'b10:   tap_sel = tap_65536hz;
            default: tap_sel = tap_16384hz;
        endcase
    end

`ifdef TIMER_TAC_GLITCH_EN
    // Edge detector on the enable-gated source: dropping tac[2] or switching
    // to a low tap while the old source is high looks like a falling edge.
    logic src;
    assign src       = tac[2] & tap_sel;
    assign edge_next = src;
    assign inc       = edge_prev & ~src;
`else
    // Edge detector on the raw tap; clearing it on a TAC write hides the
    // discontinuity caused by a source change, and the enable only gates inc.
    assign edge_next = wr_tac ? 1'b0 : tap_sel;
    assign inc       = tac[2] & edge_prev & ~tap_sel;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            edge_prev <= 1'b0;
        end else begin
            edge_prev <= edge_next;
            if (wr_tma) begin
                tma <= d;
            end
            if (wr_tac) begin
                tac <= d[2:0];
            end
            case (state)
                ST_IDLE: begin
                    if (wr_tima) begin
                        tima <= d;
                    end else if (inc) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            cnt   <= CNT_INIT;
                            state <= ST_OVF;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                ST_OVF: begin
                    // A CPU write here aborts the pending reload and IRQ.
                    if (wr_tima) begin
                        tima  <= d;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd1) begin
                            state <= ST_RELOAD;
                        end
                    end
                end
                ST_RELOAD: begin
                    // TIMA writes and increments are dropped this cycle.
                    tima  <= tma_next;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign int_timer = (state == ST_RELOAD);

    always_comb begin
        rd_data = tima;
        if (ff06) begin
            rd_data = tma;
        end else if (ff07) begin
            rd_data = {TAC_FILL, tac};
        end
    end

    assign rd_en = cpu_rd & (ff05 | ff06 | ff07);
    assign d     = rd_en ? rd_data : 8'bzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_timer_tima.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_tima
//  Purpose  : Scoreboard bench for timer_tima. The driver issues one bus
//             operation per cycle and queues the expected bus read value and
//             int_timer level; a monitor on the falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_tima;

    localparam int OVF_DELAY = 1;

    logic       clk = 1'b0;
    logic       nreset;
    logic       tap_4096hz, tap_262144hz, tap_65536hz, tap_16384hz;
    logic       ff05, ff06, ff07, cpu_wr, cpu_rd;
    logic [7:0] drv;
    logic       drv_en;
    wire  [7:0] d;
    logic       int_timer;
    logic       chk;

    assign d = drv_en ? drv : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    timer_tima #(.OVF_DELAY(OVF_DELAY), .TAC_FILL(5'b11111)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .tap_4096hz   (tap_4096hz),
        .tap_262144hz (tap_262144hz),
        .tap_65536hz  (tap_65536hz),
        .tap_16384hz  (tap_16384hz),
        .ff05         (ff05),
        .ff06         (ff06),
        .ff07         (ff07),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .d            (d),
        .int_timer    (int_timer)
    );

    typedef struct {
        string      name;
        bit         chk_d;
        logic [7:0] exp_d;
        bit         exp_int;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    // Monitor: one queued expectation per checked cycle.
    always @(negedge clk) begin
        if (chk) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.chk_d) begin
                    total++;
                    if (d !== e.exp_d)
                        $display("FAIL %s: d=%02h required %02h", e.name, d, e.exp_d);
                    else
                        passed++;
                end
                total++;
                if (int_timer !== e.exp_int)
                    $display("FAIL %s_int: int_timer=%0b required %0b", e.name, int_timer, e.exp_int);
                else
                    passed++;
            end
        end
    end

    // One bus cycle: sel is 5/6/7 for FF05/FF06/FF07, 0 for none.
    task automatic op(input int sel, input bit wr, input bit rd, input logic [7:0] wdata,
                      input bit chk_d, input logic [7:0] exp_d, input bit exp_int,
                      input string name);
        exp_t e;
        ff05   = (sel == 5);
        ff06   = (sel == 6);
        ff07   = (sel == 7);
        cpu_wr = wr;
        cpu_rd = rd;
        drv    = wdata;
        drv_en = wr;
        chk    = 1'b1;
        e.name = name; e.chk_d = chk_d; e.exp_d = exp_d; e.exp_int = exp_int;
        q.push_back(e);
        @(posedge clk);
        #1;
        ff05 = 0; ff06 = 0; ff07 = 0; cpu_wr = 0; cpu_rd = 0; drv_en = 0; chk = 0;
    endtask

    task automatic rd(input int sel, input logic [7:0] exp_d, input bit exp_int, input string name);
        op(sel, 1'b0, 1'b1, 8'h00, 1'b1, exp_d, exp_int, name);
    endtask

    task automatic wr(input int sel, input logic [7:0] data, input bit exp_int, input string name);
        op(sel, 1'b1, 1'b0, data, 1'b0, 8'h00, exp_int, name);
    endtask

    // Drive TIMA to 0xFF and produce one falling edge on tap_262144hz (TAC=0x05).
    task automatic overflow_from_ff(input string name);
        wr(5, 8'hFF, 1'b0, {name, "_wr_ff"});
        tap_262144hz = 1'b1;
        rd(5, 8'hFF, 1'b0, {name, "_pre"});
        tap_262144hz = 1'b0;
        rd(5, 8'hFF, 1'b0, {name, "_inc"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        tap_4096hz = 0; tap_262144hz = 0; tap_65536hz = 0; tap_16384hz = 0;
        ff05 = 0; ff06 = 0; ff07 = 0; cpu_wr = 0; cpu_rd = 0;
        drv = 8'h00; drv_en = 0; chk = 0;
        repeat (3) @(posedge clk);
        #1;
        op(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "reset_int");
        nreset = 1'b1;
        rd(5, 8'h00, 1'b0, "reset_tima");
        rd(6, 8'h00, 1'b0, "reset_tma");
        rd(7, 8'hF8, 1'b0, "reset_tac");

        // Counting: TAC=0x05, four falling edges, each visible one clock later.
        wr(7, 8'h05, 1'b0, "count_tac");
        for (int i = 0; i < 4; i++) begin
            tap_262144hz = 1'b1;
            rd(5, 8'(i), 1'b0, "count_high");
            tap_262144hz = 1'b0;
            rd(5, 8'(i), 1'b0, "count_fall");
        end
        rd(5, 8'h04, 1'b0, "count_final");
        rd(7, 8'hFD, 1'b0, "count_tac_rd");

        // Asynchronous reset in mid-cycle while counting.
        nreset = 1'b0;
        op(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "midreset_int");
        nreset = 1'b1;
        rd(5, 8'h00, 1'b0, "midreset_tima");
        rd(6, 8'h00, 1'b0, "midreset_tma");
        rd(7, 8'hF8, 1'b0, "midreset_tac");

        // Overflow with reload from TMA=0xA0.
        wr(6, 8'hA0, 1'b0, "ovf_tma");
        wr(7, 8'h05, 1'b0, "ovf_tac");
        overflow_from_ff("ovf");
        for (int k = 0; k < OVF_DELAY; k++)
            rd(5, 8'h00, 1'b0, "ovf_zero");
        rd(5, 8'h00, 1'b1, "ovf_reload");
        rd(5, 8'hA0, 1'b0, "ovf_after");
        rd(5, 8'hA0, 1'b0, "ovf_after2");

        // TIMA write during OVF cancels reload and interrupt.
        overflow_from_ff("cancel");
        wr(5, 8'h33, 1'b0, "cancel_wr");
        rd(5, 8'h33, 1'b0, "cancel_rd1");
        rd(5, 8'h33, 1'b0, "cancel_rd2");
        rd(6, 8'hA0, 1'b0, "cancel_tma");

        // TMA write plus an ignored increment in the RELOAD cycle.
        overflow_from_ff("rl_tma");
        for (int k = 0; k < OVF_DELAY; k++) begin
            tap_262144hz = 1'b1;
            rd(5, 8'h00, 1'b0, "rl_tma_zero");
        end
        tap_262144hz = 1'b0;
        wr(6, 8'h77, 1'b1, "rl_tma_wr");
        rd(5, 8'h77, 1'b0, "rl_tma_tima");
        rd(5, 8'h77, 1'b0, "rl_tma_tima2");

        // TIMA write in the RELOAD cycle is ignored.
        overflow_from_ff("rl_tima");
        for (int k = 0; k < OVF_DELAY; k++)
            rd(5, 8'h00, 1'b0, "rl_tima_zero");
        wr(5, 8'h11, 1'b1, "rl_tima_wr");
        rd(5, 8'h77, 1'b0, "rl_tima_tima");

        // TAC change while the selected source is high.
        wr(5, 8'h40, 1'b0, "glitch_tima");
        wr(7, 8'h07, 1'b0, "glitch_tac7");
        tap_16384hz = 1'b1;
        rd(5, 8'h40, 1'b0, "glitch_high");
        wr(7, 8'h04, 1'b0, "glitch_tac4");
        rd(5, 8'h40, 1'b0, "glitch_next");
`ifdef TIMER_TAC_GLITCH_EN
        rd(5, 8'h41, 1'b0, "glitch_result");
`else
        rd(5, 8'h40, 1'b0, "glitch_result");
`endif
        rd(7, 8'hFC, 1'b0, "glitch_tac_rd");

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
